mem_bus_arbiter: RTL and testbench

// - Shares one MemBusReq/MemBusResp memory port between the instruction-side and data-side caches.
// - Forwards one request at a time and tracks the owner of the single outstanding read.
// - Routes the read response back to that owner only.
// - Sits between the I$/D$ bus ports and the memory controller / top-level bus.

---
 rtl/mem_bus_arbiter_if.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus interface shared by the cache ports and the downstream memory port.
// A request is accepted in the cycle where req_valid && req_ready. Reads come
// back later as one resp_valid pulse. Writes get no response.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  // Requester side: issues requests and receives responses.
  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  // Responder side: accepts requests and returns responses.
  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the I-cache and D-cache.
// One request is forwarded at a time, with no added latency. The module
// remembers which side owns the single outstanding read and sends the
// response back to that side only.
// Optional feature: define MEM_ARB_RR_EN to get round-robin arbitration on
// conflicts. Without it, D has fixed priority.
module mem_bus_arbiter (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   ibus,
  mem_bus_arbiter_if.slave   dbus,
  mem_bus_arbiter_if.master  membus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT_I = 2'b01,
    ST_WAIT_D = 2'b10
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e state_q;
  logic   lock_valid_q;
  owner_e lock_owner_q;
`ifdef MEM_ARB_RR_EN
  owner_e last_grant_q;
`endif

  owner_e grant_s;
  logic   grant_valid_s;
  logic   fwd_valid_s;
  logic   accept_s;

  // Pick the side to present downstream. A stalled request keeps its grant
  // until it is accepted.
  always_comb begin
    grant_s       = OWN_I;
    grant_valid_s = 1'b0;
    if (lock_valid_q) begin
      grant_s = lock_owner_q;
      if (lock_owner_q == OWN_D) begin
        grant_valid_s = dbus.req_valid;
      end else begin
        grant_valid_s = ibus.req_valid;
      end
    end else if (ibus.req_valid && dbus.req_valid) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant_q == OWN_I) begin
        grant_s = OWN_D;
      end else begin
        grant_s = OWN_I;
      end
`else
      grant_s = OWN_D;
`endif
      grant_valid_s = 1'b1;
    end else if (dbus.req_valid) begin
      grant_s       = OWN_D;
      grant_valid_s = 1'b1;
    end else if (ibus.req_valid) begin
      grant_s       = OWN_I;
      grant_valid_s = 1'b1;
    end else begin
      grant_s       = OWN_I;
      grant_valid_s = 1'b0;
    end
  end

  // Forward only while IDLE and out of reset. Acceptance is the downstream
  // handshake on the forwarded request.
  always_comb begin
    fwd_valid_s = (state_q == ST_IDLE) && !reset && grant_valid_s;
    accept_s    = fwd_valid_s && membus.req_ready;
  end

  // Downstream request mux. The address and data follow the grant. Only
  // valid is gated.
  assign membus.req_valid = fwd_valid_s;
  assign membus.req_addr  = (grant_s == OWN_D) ? dbus.req_addr  : ibus.req_addr;
  assign membus.req_wen   = (grant_s == OWN_D) ? dbus.req_wen   : ibus.req_wen;
  assign membus.req_wdata = (grant_s == OWN_D) ? dbus.req_wdata : ibus.req_wdata;

  // Only the granted side sees the downstream ready.
  assign ibus.req_ready = accept_s && (grant_s == OWN_I);
  assign dbus.req_ready = accept_s && (grant_s == OWN_D);

  // Response routing: valid goes only to the read owner. rdata is broadcast.
  // A response that arrives in IDLE (stray, or after a reset) is dropped.
  assign ibus.resp_valid = (state_q == ST_WAIT_I) && !reset && membus.resp_valid;
  assign dbus.resp_valid = (state_q == ST_WAIT_D) && !reset && membus.resp_valid;
  assign ibus.resp_rdata = membus.resp_rdata;
  assign dbus.resp_rdata = membus.resp_rdata;

  // Arbiter FSM: grant lock, read-owner tracking and last-grant history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_I;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_I;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            lock_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= grant_s;
`endif
            if (!membus.req_wen) begin
              if (grant_s == OWN_D) begin
                state_q <= ST_WAIT_D;
              end else begin
                state_q <= ST_WAIT_I;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (fwd_valid_s) begin
            lock_valid_q <= 1'b1;
            lock_owner_q <= grant_s;
          end else begin
            lock_valid_q <= lock_valid_q;
          end
        end
        ST_WAIT_I: begin
          if (membus.resp_valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_I;
          end
        end
        ST_WAIT_D: begin
          if (membus.resp_valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_D;
          end
        end
        default: begin
`ifndef SYNTHESIS
          $display("ERROR: mem_bus_arbiter entered unknown state %b", state_q);
          $finish;
`endif
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. The stimulus pushes the expected
// downstream requests and cache responses. A negedge monitor pops and
// compares them whenever the DUT presents a handshake or a response pulse.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if ib ();
  mem_bus_arbiter_if db ();
  mem_bus_arbiter_if mb ();

  mem_bus_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .ibus   (ib),
    .dbus   (db),
    .membus (mb)
  );

  typedef struct packed {
    logic        side;   // 0 = I, 1 = D
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        side;
    logic [31:0] rdata;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc[2];
  int rsp_cyc[2];

  // memory responder state
  logic        pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = 32'h0;
  int          mem_lat   = 3;
  logic        stray     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_data = 32'hDEAD_BEEF;
      32'h0000_0200: mem_data = 32'hCAFE_F00D;
      32'h0000_0500: mem_data = 32'h55AA_55AA;
      default:       mem_data = 32'hA5A5_A5A5;
    endcase
  endfunction

  // Monitor: compares accepted requests and response pulses with the queues.
  initial begin
    req_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mb.req_valid && mb.req_ready) begin
        check("ready_onehot", {31'b0, ib.req_ready ^ db.req_ready}, 32'd1);
        acc_cyc[db.req_ready ? 1 : 0] = cyc;
        if (!mb.req_wen) begin
          pend      = 1'b1;
          pend_cnt  = mem_lat;
          pend_addr = mb.req_addr;
        end
        if (exp_req_q.size() == 0) begin
          fail_now($sformatf("unexpected_req addr=0x%08h", mb.req_addr));
        end else begin
          e = exp_req_q.pop_front();
          check("req_side",  {31'b0, db.req_ready}, {31'b0, e.side});
          check("req_addr",  mb.req_addr,           e.addr);
          check("req_wen",   {31'b0, mb.req_wen},   {31'b0, e.wen});
          if (mb.req_wen) check("req_wdata", mb.req_wdata, e.wdata);
        end
      end
      if (ib.resp_valid || db.resp_valid) begin
        check("resp_onehot", {31'b0, ib.resp_valid & db.resp_valid}, 32'd0);
        rsp_cyc[db.resp_valid ? 1 : 0] = cyc;
        if (exp_rsp_q.size() == 0) begin
          fail_now($sformatf("unexpected_resp i=%0b d=%0b", ib.resp_valid, db.resp_valid));
        end else begin
          r = exp_rsp_q.pop_front();
          check("resp_side", {31'b0, db.resp_valid}, {31'b0, r.side});
          check("resp_rdata", r.side ? db.resp_rdata : ib.resp_rdata, r.rdata);
        end
      end
    end
  end

  // Memory model: returns one response pulse mem_lat cycles after a read is
  // accepted. It can also inject a stray pulse.
  initial begin
    mb.resp_valid = 1'b0;
    mb.resp_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mb.resp_valid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          mb.resp_valid = 1'b1;
          mb.resp_rdata = mem_data(pend_addr);
          pend          = 1'b0;
        end
      end
      if (stray) begin
        mb.resp_valid = 1'b1;
        mb.resp_rdata = 32'hBAD0_BAD0;
        stray         = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requester: holds the request until it is accepted, then drops valid.
  task automatic drive(input logic side, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata);
    int   budget;
    logic acc;
    budget = 0;
    acc    = 1'b0;
    if (side) begin
      db.req_valid = 1'b1; db.req_addr = addr; db.req_wen = wen; db.req_wdata = wdata;
    end else begin
      ib.req_valid = 1'b1; ib.req_addr = addr; ib.req_wen = wen; ib.req_wdata = wdata;
    end
    while (!acc && budget < 60) begin
      @(negedge clk);
      acc = side ? (db.req_valid && db.req_ready) : (ib.req_valid && ib.req_ready);
      budget++;
    end
    if (!acc) fail_now($sformatf("accept_timeout side=%0d addr=0x%08h", side, addr));
    @(posedge clk);
    #1;
    if (side) db.req_valid = 1'b0;
    else      ib.req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_req_q.size() != 0 || exp_rsp_q.size() != 0) && b < 100) begin
      @(posedge clk);
      b++;
    end
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0)
      fail_now($sformatf("drain_timeout req=%0d rsp=%0d", exp_req_q.size(), exp_rsp_q.size()));
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset        = 1'b1;
    ib.req_valid = 1'b1; ib.req_addr = 32'h100; ib.req_wen = 1'b0; ib.req_wdata = 32'h0;
    db.req_valid = 1'b1; db.req_addr = 32'h200; db.req_wen = 1'b0; db.req_wdata = 32'h0;
    mb.req_ready = 1'b1;

    // reset held: nothing forwarded, no ready, no response
    @(negedge clk);
    check("rst_memreq_valid", {31'b0, mb.req_valid}, 32'd0);
    check("rst_iready",       {31'b0, ib.req_ready}, 32'd0);
    check("rst_dready",       {31'b0, db.req_ready}, 32'd0);
    check("rst_iresp_valid",  {31'b0, ib.resp_valid}, 32'd0);
    check("rst_dresp_valid",  {31'b0, db.resp_valid}, 32'd0);
    ib.req_valid = 1'b0;
    db.req_valid = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);

    // I read alone: forwarded in the same cycle, response 3 cycles later
    mem_lat = 3;
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    c0 = cyc;
    drive(1'b0, 32'h100, 1'b0, 32'h0);
    check("t1_zero_latency", 32'(acc_cyc[0] - c0), 32'd0);
    drain();
    check("t1_resp_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);

    // conflict: D goes first, I is forwarded the cycle after D's response
    mem_lat = 1;
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    fork
      drive(1'b1, 32'h200, 1'b0, 32'h0);
      drive(1'b0, 32'h100, 1'b0, 32'h0);
    join
    check("t2_i_after_dresp", 32'(acc_cyc[0] - rsp_cyc[1]), 32'd1);
    drain();

    // D write plus pending I read: write accepted, I read forwarded next cycle
    exp_req_q.push_back('{1'b1, 32'h300, 1'b1, 32'h0000_1234});
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    fork
      drive(1'b1, 32'h300, 1'b1, 32'h0000_1234);
      drive(1'b0, 32'h100, 1'b0, 32'h0);
    join
    check("t3_i_after_write", 32'(acc_cyc[0] - acc_cyc[1]), 32'd1);
    drain();

    // tie following a D grant: fixed priority keeps D, round robin picks I
    mem_lat = 2;
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    drain();
`ifdef MEM_ARB_RR_EN
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
`else
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
`endif
    fork
      drive(1'b1, 32'h200, 1'b0, 32'h0);
      drive(1'b0, 32'h100, 1'b0, 32'h0);
    join
    drain();

    // lock: a stalled I read keeps the port although D arrives one cycle later
    mem_lat = 1;
    mb.req_ready = 1'b0;
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
    fork
      drive(1'b0, 32'h100, 1'b0, 32'h0);
      begin
        tick(1);
        drive(1'b1, 32'h200, 1'b0, 32'h0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t5_lock_valid", {31'b0, mb.req_valid}, 32'd1);
          check("t5_lock_addr",  mb.req_addr,           32'h100);
          check("t5_lock_dready", {31'b0, db.req_ready}, 32'd0);
        end
        tick(1);
        mb.req_ready = 1'b1;
      end
    join
    drain();

    // reset while waiting for D: the late response must be dropped
    mem_lat = 6;
    exp_req_q.push_back('{1'b1, 32'h500, 1'b0, 32'h0});
    drive(1'b1, 32'h500, 1'b0, 32'h0);
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_memreq_valid", {31'b0, mb.req_valid},  32'd0);
    check("t6_rst_dresp_valid",  {31'b0, db.resp_valid}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(7);
    mem_lat = 1;
    exp_req_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    c0 = cyc;
    drive(1'b0, 32'h100, 1'b0, 32'h0);
    check("t6_idle_after_reset", 32'(acc_cyc[0] - c0), 32'd0);
    drain();

    // stray response in IDLE: dropped, and the arbiter is still IDLE
    stray = 1'b1;
    tick(3);
    exp_req_q.push_back('{1'b1, 32'h200, 1'b0, 32'h0});
    exp_rsp_q.push_back('{1'b1, 32'hCAFE_F00D});
    c0 = cyc;
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    check("t7_idle_after_stray", 32'(acc_cyc[1] - c0), 32'd0);
    drain();

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
